// File: rtl/fetch_unit.sv
// Instruction fetch unit: program counter, opcode/operand registers and ROM address mux.
// Define FETCH_CHECK_EN to build the fetch-phase tracker and the sticky o_fetch_err flag.
module fetch_unit (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pc_en,
  input  logic       i_rom_cen,
  input  logic       i_rom_ren,
  input  logic [1:0] i_fetch_mode,
  input  logic       i_addr_sel,
  input  logic [7:0] i_rom_data,
  output logic [7:0] o_rom_addr,
  output logic [2:0] o_ins,
  output logic [4:0] o_reg_addr,
  output logic [7:0] o_mem_addr,
  output logic [7:0] o_pc,
  output logic       o_fetch_err
);

  localparam logic [1:0] MODE_OP   = 2'b01;
  localparam logic [1:0] MODE_OPND = 2'b10;

  logic [7:0] pc_reg;
  logic [7:0] ir1_reg;
  logic [7:0] ir2_reg;

  logic rom_access;
  logic op_strobe;
  logic opnd_strobe;

  assign rom_access  = i_rom_cen & i_rom_ren;
  assign op_strobe   = rom_access & ~i_addr_sel & (i_fetch_mode == MODE_OP);
  assign opnd_strobe = rom_access & ~i_addr_sel & (i_fetch_mode == MODE_OPND);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pc_reg  <= 8'h00;
      ir1_reg <= 8'h00;
      ir2_reg <= 8'h00;
    end else begin
      // 8-bit add wraps 8'hFF to 8'h00 naturally
      if (i_pc_en)     pc_reg  <= pc_reg + 8'h01;
      if (op_strobe)   ir1_reg <= i_rom_data;
      if (opnd_strobe) ir2_reg <= i_rom_data;
    end
  end

  assign o_rom_addr = i_addr_sel ? ir2_reg : pc_reg;
  assign o_ins      = ir1_reg[7:5];
  assign o_reg_addr = ir1_reg[4:0];
  assign o_mem_addr = ir2_reg;
  assign o_pc       = pc_reg;

`ifdef FETCH_CHECK_EN
  localparam logic [0:0] P_OP   = 1'b0;
  localparam logic [0:0] P_OPND = 1'b1;

  logic [0:0] phase_reg;
  logic [0:0] phase_next;
  logic       err_reg;
  logic       err_next;
  logic       needs_operand;
  logic       operand_via_ir2;

  // LDO, LDA and STO are the two-byte instructions
  assign needs_operand = (i_rom_data[7:5] == 3'b001) |
                         (i_rom_data[7:5] == 3'b010) |
                         (i_rom_data[7:5] == 3'b011);

  // A fetch attempted while the address mux points at IR2 is a sequencing error
  assign operand_via_ir2 = rom_access & i_addr_sel &
                           ((i_fetch_mode == MODE_OP) | (i_fetch_mode == MODE_OPND));

  always_comb begin
    phase_next = phase_reg;
    if (op_strobe)
      phase_next = needs_operand ? P_OPND : P_OP;
    else if (opnd_strobe)
      phase_next = P_OP;
  end

  always_comb begin
    err_next = err_reg;
    if ((op_strobe & (phase_reg == P_OPND)) |
        (opnd_strobe & (phase_reg == P_OP)) |
        operand_via_ir2)
      err_next = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      phase_reg <= P_OP;
      err_reg   <= 1'b0;
    end else begin
      phase_reg <= phase_next;
      err_reg   <= err_next;
    end
  end

  assign o_fetch_err = err_reg;
`else
  assign o_fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; a behavioural ROM answers o_rom_addr.
// Error-flag expectations follow whether FETCH_CHECK_EN is defined.
module tb_fetch_unit;

`ifdef FETCH_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       pc_en;
  logic       rom_cen;
  logic       rom_ren;
  logic [1:0] fetch_mode;
  logic       addr_sel;
  logic [7:0] rom_data;
  logic [7:0] rom_addr;
  logic [2:0] ins;
  logic [4:0] reg_addr;
  logic [7:0] mem_addr;
  logic [7:0] pc;
  logic       fetch_err;

  logic [7:0] rom [256];

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pc_en      (pc_en),
    .i_rom_cen    (rom_cen),
    .i_rom_ren    (rom_ren),
    .i_fetch_mode (fetch_mode),
    .i_addr_sel   (addr_sel),
    .i_rom_data   (rom_data),
    .o_rom_addr   (rom_addr),
    .o_ins        (ins),
    .o_reg_addr   (reg_addr),
    .o_mem_addr   (mem_addr),
    .o_pc         (pc),
    .o_fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of controller signals, then sample 1 time unit after the edge
  task automatic step(input logic en, input logic cen, input logic [1:0] mode, input logic sel);
    pc_en      = en;
    rom_cen    = cen;
    rom_ren    = cen;
    fetch_mode = mode;
    addr_sel   = sel;
    @(posedge clk);
    #1;
    pc_en      = 1'b0;
    rom_cen    = 1'b0;
    rom_ren    = 1'b0;
    fetch_mode = 2'b00;
    addr_sel   = 1'b0;
    $display("step en=%b cen=%b mode=%b sel=%b -> pc=%h ins=%h reg=%h mem=%h err=%b",
             en, cen, mode, sel, pc, ins, reg_addr, mem_addr, fetch_err);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i);
    rom[0] = 8'h25;
    rom[1] = 8'h3C;
    rom[4] = 8'hE0;
    rom[6] = 8'h40;
    rom[7] = 8'hA5;

    rst = 1'b0; pc_en = 1'b0; rom_cen = 1'b0; rom_ren = 1'b0;
    fetch_mode = 2'b00; addr_sel = 1'b0;
    #2;
    chk("rst_pc", pc, 8'h00);
    chk("rst_ins", {5'b0, ins}, 8'h00);
    chk("rst_mem", mem_addr, 8'h00);
    chk("rst_rom_addr", rom_addr, 8'h00);
    chk("rst_err", {7'b0, fetch_err}, 8'h00);
    #1 rst = 1'b1;

    // Opcode 8'h25 then operand 8'h3C
    step(1'b0, 1'b1, 2'b01, 1'b0);
    step(1'b1, 1'b0, 2'b00, 1'b0);
    chk("op_ins", {5'b0, ins}, 8'h01);
    chk("op_reg", {3'b0, reg_addr}, 8'h05);
    chk("op_pc", pc, 8'h01);
    step(1'b0, 1'b1, 2'b10, 1'b0);
    step(1'b1, 1'b0, 2'b00, 1'b0);
    chk("opnd_mem", mem_addr, 8'h3C);
    chk("opnd_pc", pc, 8'h02);
    chk("opnd_err", {7'b0, fetch_err}, 8'h00);

    // Address mux
    addr_sel = 1'b1; #1;
    chk("mux_ir2", rom_addr, 8'h3C);
    addr_sel = 1'b0; #1;
    chk("mux_pc", rom_addr, 8'h02);

    // Fetch and increment in the same cycle at PC=4
    step(1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b1, 1'b0, 2'b00, 1'b0);
    chk("pc4", pc, 8'h04);
    step(1'b1, 1'b1, 2'b01, 1'b0);
    chk("hlt_ins", {5'b0, ins}, 8'h07);
    chk("hlt_reg", {3'b0, reg_addr}, 8'h00);
    chk("hlt_pc", pc, 8'h05);
    chk("hlt_err", {7'b0, fetch_err}, 8'h00);
    step(1'b1, 1'b0, 2'b00, 1'b0);
    chk("hlt_pc_runs", pc, 8'h06);

    // LDA followed by a second opcode fetch
    step(1'b0, 1'b1, 2'b01, 1'b0);
    chk("lda_ins", {5'b0, ins}, 8'h02);
    chk("lda_err", {7'b0, fetch_err}, 8'h00);
    step(1'b0, 1'b1, 2'b01, 1'b0);
    chk("dbl_op_err", {7'b0, fetch_err}, {7'b0, CHK});
    step(1'b1, 1'b0, 2'b00, 1'b0);
    chk("err_sticky", {7'b0, fetch_err}, {7'b0, CHK});
    chk("pc7", pc, 8'h07);

    // Holds: reserved mode, missing enables
    step(1'b0, 1'b1, 2'b11, 1'b0);
    chk("mode11_ins", {5'b0, ins}, 8'h02);
    step(1'b0, 1'b0, 2'b01, 1'b0);
    chk("nocen_ins", {5'b0, ins}, 8'h02);
    step(1'b0, 1'b0, 2'b10, 1'b0);
    chk("nocen_mem", mem_addr, 8'h3C);

    // Asynchronous reset while in P_OPND
    rst = 1'b0; #1;
    chk("arst_pc", pc, 8'h00);
    chk("arst_ins", {5'b0, ins}, 8'h00);
    chk("arst_mem", mem_addr, 8'h00);
    chk("arst_err", {7'b0, fetch_err}, 8'h00);
    #1 rst = 1'b1;
    step(1'b0, 1'b1, 2'b10, 1'b0);
    chk("post_rst_mem", mem_addr, 8'h25);
    chk("post_rst_err", {7'b0, fetch_err}, {7'b0, CHK});

    // PC wrap
    rst = 1'b0; #1; rst = 1'b1;
    for (int i = 0; i < 255; i++) step(1'b1, 1'b0, 2'b00, 1'b0);
    chk("pc_ff", pc, 8'hFF);
    step(1'b1, 1'b0, 2'b00, 1'b0);
    chk("pc_wrap", pc, 8'h00);
    chk("wrap_err", {7'b0, fetch_err}, 8'h00);

    // Opcode fetch attempted through the IR2 address path
    step(1'b0, 1'b1, 2'b01, 1'b1);
    chk("sel_ins", {5'b0, ins}, 8'h00);
    chk("sel_err", {7'b0, fetch_err}, {7'b0, CHK});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port i_clk, input, 1: rising-edge system clock.
REQ-002 SHALL have port i_rst, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port i_pc_en, input, 1: increment the program counter at the next edge.
REQ-004 SHALL have port i_rom_cen, input, 1: ROM chip enable from the controller.
REQ-005 SHALL have port i_rom_ren, input, 1: ROM read enable from the controller.
REQ-006 SHALL have port i_fetch_mode, input, 2: 00 hold, 01 latch opcode byte (IR1), 10 latch operand byte (IR2), 11 reserved (hold).
REQ-007 SHALL have port i_addr_sel, input, 1: ROM address source; 0 = PC, 1 = IR2.
REQ-008 SHALL have port i_rom_data, input, 8: ROM read data, combinationally valid for the o_rom_addr of the same cycle.
REQ-009 SHALL have port o_rom_addr, output, 8: ROM address.
REQ-010 SHALL have port o_ins, output, 3: opcode, IR1[7:5].
REQ-011 SHALL have port o_reg_addr, output, 5: register address, IR1[4:0].
REQ-012 SHALL have port o_mem_addr, output, 8: operand address, IR2.
REQ-013 SHALL have port o_pc, output, 8: current program counter.
REQ-014 SHALL have port o_fetch_err, output, 1: sticky fetch-sequence error flag.

Function
REQ-015 o_rom_addr SHALL be combinational: i_addr_sel ? IR2 : PC.
REQ-016 A fetch strobe SHALL be defined as i_rom_cen & i_rom_ren & ~i_addr_sel & (i_fetch_mode == 01 or 10).
REQ-017 On a fetch strobe with mode 01, IR1 SHALL load i_rom_data at the rising edge; o_ins/o_reg_addr SHALL update the following cycle.
REQ-018 On a fetch strobe with mode 10, IR2 SHALL load i_rom_data at the rising edge.
REQ-019 Modes 00 and 11, or a missing cen/ren, SHALL leave IR1 and IR2 unchanged.
REQ-020 With i_pc_en=1, PC SHALL increment by 1 at the edge; 8'hFF SHALL wrap to 8'h00.
REQ-021 i_pc_en together with a fetch strobe in the same cycle SHALL do both: the IR loads data at the old PC, and PC increments.
REQ-022 The phase tracker SHALL have two states: P_OP (reset) and P_OPND.
REQ-023 The tracker SHALL go P_OP -> P_OPND on a mode-01 strobe whose opcode (i_rom_data[7:5]) is LDO 001, LDA 010 or STO 011; other opcodes SHALL stay in P_OP.
REQ-024 The tracker SHALL go P_OPND -> P_OP on a mode-10 strobe.
REQ-025 o_fetch_err SHALL set at the next edge, and stay set until reset, on any of:
  - a mode-01 strobe in P_OPND;
  - a mode-10 strobe in P_OP;
  - i_fetch_mode 01/10 with i_addr_sel=1 and cen & ren.
REQ-026 An erroring mode-01 strobe SHALL still load IR1 and re-evaluate the phase per REQ-023; an erroring mode-10 strobe in P_OP SHALL still load IR2.
REQ-027 Once opcode HLT 111 is latched in IR1, the block SHALL keep updating PC and IRs as commanded; halting is the controller's responsibility.

Reset
REQ-028 i_rst low SHALL immediately clear PC, IR1, IR2 and o_fetch_err to 0 and set the phase to P_OP, so o_ins=NOP and o_rom_addr=0.
REQ-029 Reset asserted mid-instruction (in P_OPND) SHALL abandon the instruction; the first strobe after release SHALL be treated as an opcode fetch.
REQ-030 Release of reset SHALL take effect synchronously at the first rising edge with i_rst high.

Configuration
REQ-031 Macro FETCH_CHECK_EN defined: the phase tracker and o_fetch_err logic SHALL be present as specified.
REQ-032 Macro FETCH_CHECK_EN undefined: the phase tracker SHALL be absent, o_fetch_err SHALL be tied to 0, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset, then ROM[0]=8'h25, mode 01 strobe, then pc_en -> o_ins=001, o_reg_addr=5'h05, o_pc=1; after ROM[1]=8'h3C, mode 10 strobe, then pc_en -> o_mem_addr=8'h3C, o_pc=2, o_fetch_err=0.
REQ-034 i_addr_sel=1 with IR2=8'h3C -> o_rom_addr=8'h3C; i_addr_sel=0 -> o_rom_addr=o_pc.
REQ-035 PC preloaded to 8'hFF by 255 pc_en pulses, one more pc_en -> o_pc=8'h00.
REQ-036 Opcode 8'h40 (LDA) latched, then another mode-01 strobe -> o_fetch_err=1 and it stays 1 until i_rst low; with FETCH_CHECK_EN undefined -> stays 0.
REQ-037 Mode 01 strobe with pc_en in the same cycle at PC=4, ROM[4]=8'hE0 -> IR1=8'hE0 (o_ins=HLT), o_pc=5.
REQ-038 i_rst pulsed low while in P_OPND -> outputs 0 immediately; a following mode-10 strobe -> o_fetch_err=1.
